// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with execute-operand forwarding muxes, load-use
// hazard detection, bubble insertion and a saturating load-use bubble counter.
module id_ex_stage #(
   parameter int DATA_W = 32,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              id_valid,
   input  logic [4:0]        id_rs_a,
   input  logic [4:0]        id_rt_a,
   input  logic [4:0]        id_rd_a,
   input  logic              id_uses_rt,
   input  logic [DATA_W-1:0] id_rs_data,
   input  logic [DATA_W-1:0] id_rt_data,
   input  logic [DATA_W-1:0] id_imm,
   input  logic              id_RegWrite,
   input  logic              id_MemRead,
   input  logic              id_MemWrite,
   input  logic              id_ALUSrc,
   input  logic [3:0]        id_alu_op,
   input  logic              flush,
   input  logic              mem_stall,
   input  logic [1:0]        ex_forward_a,
   input  logic [1:0]        ex_forward_b,
   input  logic [DATA_W-1:0] mem_alu_result,
   input  logic [DATA_W-1:0] wb_write_data,
   output logic [4:0]        ex_rs_a,
   output logic [4:0]        ex_rt_a,
   output logic              ex_valid,
   output logic [4:0]        ex_rd_a,
   output logic              ex_RegWrite,
   output logic              ex_MemRead,
   output logic              ex_MemWrite,
   output logic [3:0]        ex_alu_op,
   output logic [DATA_W-1:0] ex_op_a,
   output logic [DATA_W-1:0] ex_op_b,
   output logic [DATA_W-1:0] ex_store_data,
   output logic              stall,
   output logic [CNT_W-1:0]  load_use_count
);

   logic              valid_q,    valid_d;
   logic [4:0]        rs_a_q,     rs_a_d;
   logic [4:0]        rt_a_q,     rt_a_d;
   logic [4:0]        rd_a_q,     rd_a_d;
   logic              regwrite_q, regwrite_d;
   logic              memread_q,  memread_d;
   logic              memwrite_q, memwrite_d;
   logic              alusrc_q,   alusrc_d;
   logic [3:0]        alu_op_q,   alu_op_d;
   logic [DATA_W-1:0] rs_data_q,  rs_data_d;
   logic [DATA_W-1:0] rt_data_q,  rt_data_d;
   logic [DATA_W-1:0] imm_q,      imm_d;
   logic [CNT_W-1:0]  cnt_q,      cnt_d;

   logic              load_use;
   logic              bubble;
   logic [DATA_W-1:0] fwd_rs;
   logic [DATA_W-1:0] fwd_rt;

   // Code 2'b11 is not a legal hazard-unit output; it falls back to the register value.
   function automatic logic [DATA_W-1:0] fwd_sel(
      input logic [1:0]        code,
      input logic [DATA_W-1:0] reg_val,
      input logic [DATA_W-1:0] mem_val,
      input logic [DATA_W-1:0] wb_val
   );
      logic [DATA_W-1:0] r;
      case (code)
         2'b10:   r = mem_val;
         2'b01:   r = wb_val;
         default: r = reg_val;
      endcase
      return r;
   endfunction

   // A bubble has rd = 0, so it can never itself raise a load-use hazard.
   assign load_use = valid_q & memread_q & (rd_a_q != 5'd0) & id_valid &
                     ((rd_a_q == id_rs_a) | (id_uses_rt & (rd_a_q == id_rt_a)));
   assign stall    = load_use | mem_stall;
   assign bubble   = flush | load_use;

   always_comb begin
      valid_d    = valid_q;
      rs_a_d     = rs_a_q;
      rt_a_d     = rt_a_q;
      rd_a_d     = rd_a_q;
      regwrite_d = regwrite_q;
      memread_d  = memread_q;
      memwrite_d = memwrite_q;
      alusrc_d   = alusrc_q;
      alu_op_d   = alu_op_q;
      rs_data_d  = rs_data_q;
      rt_data_d  = rt_data_q;
      imm_d      = imm_q;
      if (!mem_stall) begin
         if (bubble) begin
            valid_d    = 1'b0;
            rs_a_d     = 5'd0;
            rt_a_d     = 5'd0;
            rd_a_d     = 5'd0;
            regwrite_d = 1'b0;
            memread_d  = 1'b0;
            memwrite_d = 1'b0;
            alusrc_d   = 1'b0;
            alu_op_d   = 4'd0;
            rs_data_d  = '0;
            rt_data_d  = '0;
            imm_d      = '0;
         end else begin
            valid_d    = id_valid;
            rs_a_d     = id_rs_a;
            rt_a_d     = id_rt_a;
            rd_a_d     = id_rd_a;
            regwrite_d = id_RegWrite;
            memread_d  = id_MemRead;
            memwrite_d = id_MemWrite;
            alusrc_d   = id_ALUSrc;
            alu_op_d   = id_alu_op;
            rs_data_d  = id_rs_data;
            rt_data_d  = id_rt_data;
            imm_d      = id_imm;
         end
      end
   end

   // Only a bubble caused purely by load-use is counted; flush or freeze suppress it.
   always_comb begin
      cnt_d = cnt_q;
      if (load_use && !mem_stall && !flush && (cnt_q != {CNT_W{1'b1}}))
         cnt_d = cnt_q + 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q    <= 1'b0;
         rs_a_q     <= 5'd0;
         rt_a_q     <= 5'd0;
         rd_a_q     <= 5'd0;
         regwrite_q <= 1'b0;
         memread_q  <= 1'b0;
         memwrite_q <= 1'b0;
         alusrc_q   <= 1'b0;
         alu_op_q   <= 4'd0;
         rs_data_q  <= '0;
         rt_data_q  <= '0;
         imm_q      <= '0;
         cnt_q      <= '0;
      end else begin
         valid_q    <= valid_d;
         rs_a_q     <= rs_a_d;
         rt_a_q     <= rt_a_d;
         rd_a_q     <= rd_a_d;
         regwrite_q <= regwrite_d;
         memread_q  <= memread_d;
         memwrite_q <= memwrite_d;
         alusrc_q   <= alusrc_d;
         alu_op_q   <= alu_op_d;
         rs_data_q  <= rs_data_d;
         rt_data_q  <= rt_data_d;
         imm_q      <= imm_d;
         cnt_q      <= cnt_d;
      end
   end

   assign fwd_rs = fwd_sel(ex_forward_a, rs_data_q, mem_alu_result, wb_write_data);
   assign fwd_rt = fwd_sel(ex_forward_b, rt_data_q, mem_alu_result, wb_write_data);

   assign ex_valid       = valid_q;
   assign ex_rs_a        = rs_a_q;
   assign ex_rt_a        = rt_a_q;
   assign ex_rd_a        = rd_a_q;
   assign ex_RegWrite    = regwrite_q;
   assign ex_MemRead     = memread_q;
   assign ex_MemWrite    = memwrite_q;
   assign ex_alu_op      = alu_op_q;
   assign ex_op_a        = fwd_rs;
   assign ex_store_data  = fwd_rt;
   assign ex_op_b        = alusrc_q ? imm_q : fwd_rt;
   assign load_use_count = cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed scenarios plus randomized traffic
// checked against a transaction-level model of the ID/EX stage.
module tb_id_ex_stage;
   localparam int DW = 32;
   localparam int CW = 4;
   localparam int CMAX = (1 << CW) - 1;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic id_valid = 0, id_uses_rt = 0;
   logic [4:0] id_rs_a = 0, id_rt_a = 0, id_rd_a = 0;
   logic [DW-1:0] id_rs_data = 0, id_rt_data = 0, id_imm = 0;
   logic id_RegWrite = 0, id_MemRead = 0, id_MemWrite = 0, id_ALUSrc = 0;
   logic [3:0] id_alu_op = 0;
   logic flush = 0, mem_stall = 0;
   logic [1:0] ex_forward_a = 0, ex_forward_b = 0;
   logic [DW-1:0] mem_alu_result = 0, wb_write_data = 0;
   logic [4:0] ex_rs_a, ex_rt_a, ex_rd_a;
   logic ex_valid, ex_RegWrite, ex_MemRead, ex_MemWrite, stall;
   logic [3:0] ex_alu_op;
   logic [DW-1:0] ex_op_a, ex_op_b, ex_store_data;
   logic [CW-1:0] load_use_count;

   int n_cmp = 0;
   int n_bad = 0;

   typedef struct packed {
      logic v; logic [4:0] rs, rt, rd; logic rw, mr, mw, as; logic [3:0] op;
      logic [DW-1:0] rsd, rtd, imm;
   } instr_t;
   instr_t m;      // instruction the model believes sits in EX
   int     m_cnt;  // model bubble count

   id_ex_stage #(.DATA_W(DW), .CNT_W(CW)) dut (
      .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs_a(id_rs_a), .id_rt_a(id_rt_a),
      .id_rd_a(id_rd_a), .id_uses_rt(id_uses_rt), .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
      .id_imm(id_imm), .id_RegWrite(id_RegWrite), .id_MemRead(id_MemRead), .id_MemWrite(id_MemWrite),
      .id_ALUSrc(id_ALUSrc), .id_alu_op(id_alu_op), .flush(flush), .mem_stall(mem_stall),
      .ex_forward_a(ex_forward_a), .ex_forward_b(ex_forward_b), .mem_alu_result(mem_alu_result),
      .wb_write_data(wb_write_data), .ex_rs_a(ex_rs_a), .ex_rt_a(ex_rt_a), .ex_valid(ex_valid),
      .ex_rd_a(ex_rd_a), .ex_RegWrite(ex_RegWrite), .ex_MemRead(ex_MemRead), .ex_MemWrite(ex_MemWrite),
      .ex_alu_op(ex_alu_op), .ex_op_a(ex_op_a), .ex_op_b(ex_op_b), .ex_store_data(ex_store_data),
      .stall(stall), .load_use_count(load_use_count)
   );

   always #5 clk = ~clk;

   function automatic bit model_lu();
      return m.v && m.mr && (m.rd != 0) && id_valid &&
             ((m.rd == id_rs_a) || (id_uses_rt && (m.rd == id_rt_a)));
   endfunction

   function automatic logic [DW-1:0] model_fwd(input logic [1:0] code, input logic [DW-1:0] r);
      if (code == 2'b10) return mem_alu_result;
      if (code == 2'b01) return wb_write_data;
      return r;
   endfunction

   function automatic logic [122:0] got_vec();
      return {ex_valid, ex_rs_a, ex_rt_a, ex_rd_a, ex_RegWrite, ex_MemRead, ex_MemWrite,
              ex_alu_op, ex_op_a, ex_op_b, ex_store_data, load_use_count};
   endfunction

   function automatic logic [122:0] exp_vec();
      logic [DW-1:0] st;
      st = model_fwd(ex_forward_b, m.rtd);
      return {m.v, m.rs, m.rt, m.rd, m.rw, m.mr, m.mw, m.op,
              model_fwd(ex_forward_a, m.rsd), (m.as ? m.imm : st), st, CW'(m_cnt)};
   endfunction

   task automatic set_id(input logic v, input logic [4:0] rs, rt, rd, input logic ur,
                         input logic [DW-1:0] rsd, rtd, imm, input logic rw, mr, mw, as,
                         input logic [3:0] op);
      id_valid = v; id_rs_a = rs; id_rt_a = rt; id_rd_a = rd; id_uses_rt = ur;
      id_rs_data = rsd; id_rt_data = rtd; id_imm = imm;
      id_RegWrite = rw; id_MemRead = mr; id_MemWrite = mw; id_ALUSrc = as; id_alu_op = op;
   endtask

   // Advance one clock, updating the model from the inputs seen at the edge.
   task automatic tick();
      bit lu;
      lu = model_lu();
      if (!mem_stall) begin
         if (flush || lu) m = '0;
         else m = '{v: id_valid, rs: id_rs_a, rt: id_rt_a, rd: id_rd_a, rw: id_RegWrite,
                    mr: id_MemRead, mw: id_MemWrite, as: id_ALUSrc, op: id_alu_op,
                    rsd: id_rs_data, rtd: id_rt_data, imm: id_imm};
      end
      if (lu && !mem_stall && !flush && m_cnt < CMAX) m_cnt++;
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      #12;
      n_cmp++;
      if (got_vec() !== '0 || stall !== 1'b0) begin
         n_bad++; $display("FAIL reset_initial: got %h stall %b, want 0 stall 0", got_vec(), stall);
      end
      rst_n = 1'b1;
      m = '0; m_cnt = 0;
      set_id(1, 5'd3, 5'd4, 5'd8, 0, 32'h1, 32'h2, 32'h3, 1, 1, 0, 1, 4'h2); tick();
      set_id(1, 5'd8, 5'd4, 5'd9, 1, 32'h5, 32'h6, 32'h7, 1, 0, 0, 0, 4'h1); tick(); tick();
      n_cmp++;
      if (load_use_count !== 4'd1 || ex_valid !== 1'b1) begin
         n_bad++; $display("FAIL reset_setup: cnt %0d valid %b, want 1 1", load_use_count, ex_valid);
      end
      #3 rst_n = 1'b0;
      #1;
      m = '0; m_cnt = 0;
      n_cmp++;
      if (got_vec() !== '0 || stall !== 1'b0) begin
         n_bad++; $display("FAIL reset_async: got %h stall %b, want 0 stall 0", got_vec(), stall);
      end
      #2 rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_capture();
      set_id(1, 5'd1, 5'd2, 5'd3, 1, 32'h11, 32'h99, 32'h5, 1, 0, 0, 1, 4'h3);
      tick();
      n_cmp++;
      if (ex_op_a !== 32'h11 || ex_op_b !== 32'h5 || ex_valid !== 1'b1 || ex_rd_a !== 5'd3) begin
         n_bad++; $display("FAIL capture: a %h b %h v %b rd %0d, want 11 5 1 3", ex_op_a, ex_op_b, ex_valid, ex_rd_a);
      end
   endtask

   task automatic test_forward();
      set_id(1, 5'd4, 5'd5, 5'd6, 1, 32'h22, 32'h33, 32'h44, 1, 0, 1, 0, 4'h4);
      tick();
      ex_forward_a = 2'b10; mem_alu_result = 32'hAA;
      ex_forward_b = 2'b01; wb_write_data = 32'hBB;
      #1;
      n_cmp++;
      if (ex_op_a !== 32'hAA || ex_op_b !== 32'hBB || ex_store_data !== 32'hBB) begin
         n_bad++; $display("FAIL forward: a %h b %h st %h, want aa bb bb", ex_op_a, ex_op_b, ex_store_data);
      end
      ex_forward_a = 2'b11; ex_forward_b = 2'b11;
      #1;
      n_cmp++;
      if (ex_op_a !== 32'h22 || ex_op_b !== 32'h33 || ex_store_data !== 32'h33) begin
         n_bad++; $display("FAIL forward_11: a %h b %h st %h, want 22 33 33", ex_op_a, ex_op_b, ex_store_data);
      end
      ex_forward_a = 2'b00; ex_forward_b = 2'b00;
   endtask

   task automatic test_load_use();
      int c0;
      set_id(1, 5'd1, 5'd2, 5'd8, 0, 32'h0, 32'h0, 32'h10, 1, 1, 0, 1, 4'h0); tick();
      c0 = m_cnt;
      set_id(1, 5'd8, 5'd3, 5'd9, 1, 32'h12, 32'h13, 32'h0, 1, 0, 0, 0, 4'h1);
      #1;
      n_cmp++;
      if (stall !== 1'b1) begin n_bad++; $display("FAIL lu_stall: got %b want 1", stall); end
      tick();
      n_cmp++;
      if (ex_valid !== 1'b0 || ex_rd_a !== 5'd0 || load_use_count !== CW'(c0 + 1) || stall !== 1'b0) begin
         n_bad++; $display("FAIL lu_bubble: v %b rd %0d cnt %0d stall %b, want 0 0 %0d 0",
                           ex_valid, ex_rd_a, load_use_count, stall, c0 + 1);
      end
      tick();
      ex_forward_a = 2'b01; wb_write_data = 32'h77;
      #1;
      n_cmp++;
      if (ex_valid !== 1'b1 || ex_rs_a !== 5'd8 || ex_op_a !== 32'h77) begin
         n_bad++; $display("FAIL lu_recover: v %b rs %0d a %h, want 1 8 77", ex_valid, ex_rs_a, ex_op_a);
      end
      ex_forward_a = 2'b00;
      set_id(1, 5'd1, 5'd2, 5'd8, 0, 32'h0, 32'h0, 32'h10, 1, 1, 0, 1, 4'h0); tick();
      set_id(1, 5'd3, 5'd8, 5'd9, 0, 32'h1, 32'h2, 32'h3, 1, 0, 0, 1, 4'h1);
      #1;
      n_cmp++;
      if (stall !== 1'b0) begin n_bad++; $display("FAIL lu_rt_unused: got %b want 0", stall); end
      set_id(1, 5'd1, 5'd2, 5'd0, 0, 32'h0, 32'h0, 32'h10, 0, 1, 0, 1, 4'h0); tick();
      set_id(1, 5'd0, 5'd0, 5'd9, 1, 32'h1, 32'h2, 32'h3, 1, 0, 0, 0, 4'h1);
      #1;
      n_cmp++;
      if (stall !== 1'b0) begin n_bad++; $display("FAIL lu_r0: got %b want 0", stall); end
      tick();
   endtask

   task automatic test_priority();
      int c0;
      set_id(1, 5'd1, 5'd2, 5'd8, 0, 32'h0, 32'h0, 32'h10, 1, 1, 0, 1, 4'h5); tick();
      c0 = m_cnt;
      set_id(1, 5'd8, 5'd3, 5'd9, 1, 32'h12, 32'h13, 32'h0, 1, 0, 0, 0, 4'h1);
      mem_stall = 1; flush = 1;
      #1;
      n_cmp++;
      if (stall !== 1'b1) begin n_bad++; $display("FAIL prio_stall: got %b want 1", stall); end
      tick();
      n_cmp++;
      if (ex_valid !== 1'b1 || ex_rd_a !== 5'd8 || ex_MemRead !== 1'b1 || ex_alu_op !== 4'h5 ||
          load_use_count !== CW'(c0)) begin
         n_bad++; $display("FAIL prio_freeze: v %b rd %0d mr %b op %h cnt %0d, want 1 8 1 5 %0d",
                           ex_valid, ex_rd_a, ex_MemRead, ex_alu_op, load_use_count, c0);
      end
      mem_stall = 0;
      #1;
      n_cmp++;
      if (stall !== 1'b1) begin n_bad++; $display("FAIL prio_flush_stall: got %b want 1", stall); end
      tick();
      flush = 0;
      n_cmp++;
      if (ex_valid !== 1'b0 || ex_rd_a !== 5'd0 || load_use_count !== CW'(c0)) begin
         n_bad++; $display("FAIL prio_flush: v %b rd %0d cnt %0d, want 0 0 %0d", ex_valid, ex_rd_a, load_use_count, c0);
      end
   endtask

   task automatic test_saturation();
      for (int i = 0; i < CMAX + 4; i++) begin
         set_id(1, 5'd1, 5'd2, 5'd5, 0, 32'h0, 32'h0, 32'h4, 1, 1, 0, 1, 4'h0); tick();
         set_id(1, 5'd5, 5'd6, 5'd7, 1, 32'h1, 32'h2, 32'h3, 1, 0, 0, 0, 4'h1); tick();
         n_cmp++;
         if (load_use_count !== CW'(m_cnt)) begin
            n_bad++; $display("FAIL sat_step%0d: cnt %0d want %0d", i, load_use_count, m_cnt);
         end
      end
      n_cmp++;
      if (load_use_count !== CW'(CMAX)) begin
         n_bad++; $display("FAIL sat_final: cnt %0d want %0d", load_use_count, CMAX);
      end
   endtask

   task automatic test_random();
      bit lu;
      for (int i = 0; i < 400; i++) begin
         set_id($urandom_range(0, 3) != 0, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                5'($urandom_range(0, 3)), $urandom_range(0, 1) == 1, $urandom, $urandom, $urandom,
                $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                $urandom_range(0, 1) == 1, 4'($urandom));
         mem_stall = ($urandom_range(0, 7) == 0);
         flush = ($urandom_range(0, 7) == 0);
         ex_forward_a = 2'($urandom); ex_forward_b = 2'($urandom);
         mem_alu_result = $urandom; wb_write_data = $urandom;
         #1;
         lu = model_lu();
         n_cmp++;
         if (stall !== (lu | mem_stall) || got_vec() !== exp_vec()) begin
            n_bad++; $display("FAIL random%0d: got %h stall %b, want %h stall %b",
                              i, got_vec(), stall, exp_vec(), lu | mem_stall);
         end
         tick();
      end
      mem_stall = 0; flush = 0;
   endtask

   initial begin
      m = '0; m_cnt = 0;
      test_reset();
      test_capture();
      test_forward();
      test_load_use();
      test_priority();
      test_saturation();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
